// File: rtl/processor_pkg.sv
// processor_pkg: shared constants, instruction/opcode types and the boot program ROM.
package processor_pkg;
    localparam int DATA_W     = 16;
    localparam int DMEM_DEPTH = 256;
    localparam int IMEM_DEPTH = 32;
    localparam int VLEN       = 6;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LI   = 4'h1,
        OP_ST   = 4'h2,
        OP_LD   = 4'h3,
        OP_ADD  = 4'h4,
        OP_IN   = 4'h5,
        OP_VLD  = 4'h6,
        OP_VADD = 4'h7,
        OP_VST  = 4'h8,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic {S_RUN, S_HALT} state_t;

    // lo holds ra/rb in [8:6]/[5:3] or addr/imm8 in [7:0], depending on opcode
    typedef struct packed {
        logic [3:0] op;
        logic [2:0] rd;
        logic [8:0] lo;
    } instr_t;

    localparam logic [15:0] BOOT_ROM [IMEM_DEPTH] = '{
        16'h1205, 16'h2204, 16'h1207, 16'h2205, 16'h120D, 16'h2206,
        16'h1213, 16'h2207, 16'h1217, 16'h2208, 16'h1218, 16'h2209,
        16'h1202, 16'h220A, 16'h1204, 16'h220B, 16'h1206, 16'h220C,
        16'h1207, 16'h220D, 16'h1209, 16'h220E, 16'h1221, 16'h220F,
        16'h6004, 16'h620A, 16'h7008, 16'h8010, 16'hF000,
        16'hF000, 16'hF000, 16'hF000
    };
endpackage

// File: rtl/processor_vector_alu.sv
// vector_alu: lane-wise wrapping adder across all vector lanes.
module vector_alu
    import processor_pkg::*;
(
    input  logic [VLEN-1:0][DATA_W-1:0] a,
    input  logic [VLEN-1:0][DATA_W-1:0] b,
    output logic [VLEN-1:0][DATA_W-1:0] sum
);
    for (genvar i = 0; i < VLEN; i++) begin : g_lane
        assign sum[i] = a[i] + b[i];
    end
endmodule

// File: rtl/processor.sv
// processor: 16-bit scalar/vector core running the boot ROM, with a debug readout of data memory.
module processor
    import processor_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  switches,
    input  logic [23:0] parallelAddress,
    input  logic [35:0] gpio1,
    output logic [35:0] gpio2,
    output logic [15:0] q
);
    state_t state_q, state_d;
    logic [7:0] pc;
    logic [2:0] lane;
    logic [DATA_W-1:0] last_store;
    logic [DATA_W-1:0] r [8];
    logic [VLEN-1:0][DATA_W-1:0] vreg [2];
    logic [VLEN-1:0][DATA_W-1:0] vsum;
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];
    instr_t ins;
    logic [7:0] imm, vaddr;
    logic halted, run, is_vmem, last_lane, adv_pc;
    logic unused;

    assign ins       = instr_t'(BOOT_ROM[pc[4:0]]);
    assign imm       = ins.lo[7:0];
    assign vaddr     = imm + {5'b0, lane};
    assign is_vmem   = ins.op == OP_VLD || ins.op == OP_VST;
    assign last_lane = lane == 3'(VLEN - 1);
    assign gpio2     = {3'b0, halted, pc, 8'b0, last_store};
    assign unused    = ^{gpio1[35:16], parallelAddress[23:8], switches[3:1]};

    vector_alu u_valu (.a(vreg[ins.lo[6]]), .b(vreg[ins.lo[3]]), .sum(vsum));

    always_ff @(posedge clk)
        state_q <= rst ? S_RUN : state_d;

    always_comb
        state_d = run && ins.op == OP_HALT ? S_HALT : state_q;

    always_comb begin
        halted = state_q == S_HALT;
        run    = switches[0] && !halted;
        adv_pc = run && ins.op != OP_HALT && (!is_vmem || last_lane);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= '0;
            lane       <= '0;
            last_store <= '0;
            q          <= '0;
            for (int i = 0; i < 8; i++) r[i] <= '0;
            for (int i = 0; i < 2; i++) vreg[i] <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
        end else begin
            // nonblocking read sees the pre-store word, giving read-before-write
            q <= switches[4] ? dmem[parallelAddress[7:0]] : {8'b0, pc};
            if (run) begin
                lane <= is_vmem && !last_lane ? lane + 3'd1 : 3'd0;
                if (adv_pc) pc <= pc + 8'd1;
                case (ins.op)
                    OP_LI:   r[ins.rd] <= {8'b0, imm};
                    OP_ST: begin
                        dmem[imm]  <= r[ins.rd];
                        last_store <= r[ins.rd];
                    end
                    OP_LD:   r[ins.rd] <= dmem[imm];
                    OP_ADD:  r[ins.rd] <= r[ins.lo[8:6]] + r[ins.lo[5:3]];
                    OP_IN:   r[ins.rd] <= gpio1[15:0];
                    OP_VLD:  vreg[ins.rd[0]][lane] <= dmem[vaddr];
                    OP_VADD: vreg[ins.rd[0]] <= vsum;
                    OP_VST: begin
                        dmem[vaddr] <= vreg[ins.rd[0]][lane];
                        if (last_lane) last_store <= vreg[ins.rd[0]][lane];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_processor.sv
// tb_processor: scoreboard bench for the boot program, readout latency, run gating and reset abort.
module tb_processor;
    logic        clk = 0;
    logic        rst;
    logic [4:0]  switches;
    logic [23:0] parallelAddress;
    logic [35:0] gpio1;
    logic [35:0] gpio2;
    logic [15:0] q;
    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q [$];
    int tab_a [6] = '{5, 7, 13, 19, 23, 24};
    int tab_b [6] = '{2, 4, 6, 7, 9, 33};

    processor dut (
        .clk(clk), .rst(rst), .switches(switches), .parallelAddress(parallelAddress),
        .gpio1(gpio1), .gpio2(gpio2), .q(q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_model(input int a);
        if (a >= 4 && a <= 9) return 16'(tab_a[a-4]);
        if (a >= 10 && a <= 15) return 16'(tab_b[a-10]);
        if (a >= 16 && a <= 21) return 16'(tab_a[a-16] + tab_b[a-16]);
        return 16'd0;
    endfunction

    task automatic read_addr(input logic [23:0] a, input logic [15:0] e);
        parallelAddress = a;
        exp_q.push_back(e);
        @(negedge clk);
        check($sformatf("q@%0h", a), {20'b0, q}, {20'b0, exp_q.pop_front()});
    endtask

    task automatic verify_final();
        switches = 5'b10100;
        check("halted", {35'b0, gpio2[32]}, 36'd1);
        for (int a = 4; a <= 21; a++) read_addr(24'(a), mem_model(a));
        read_addr(24'h000104, mem_model(4));
        read_addr(24'hFFFF10, mem_model(16));
        read_addr(24'd22, 16'd0);
    endtask

    initial begin
        rst = 1; switches = 5'b00001; parallelAddress = 0; gpio1 = 36'h0_1234_5678;
        repeat (2) @(negedge clk);
        check("reset_q", {20'b0, q}, 36'd0);
        check("reset_gpio2", gpio2, 36'd0);
        rst = 0;
        repeat (10) @(negedge clk);
        check("pc_after_10", {28'b0, gpio2[31:24]}, 36'd10);
        repeat (43) @(negedge clk);
        verify_final();
        switches = 5'b00001;
        repeat (20) @(negedge clk);
        check("halt_hold_gpio2", gpio2, {3'b0, 1'b1, 8'd28, 8'd0, 16'd57});
        check("status_q", {20'b0, q}, 36'd28);
        verify_final();

        rst = 1; switches = 5'b00000;
        @(negedge clk);
        rst = 0;
        repeat (20) @(negedge clk);
        check("idle_q", {20'b0, q}, 36'd0);
        check("idle_gpio2", gpio2, 36'd0);
        switches = 5'b10000;
        read_addr(24'd16, 16'd0);

        switches = 5'b00001;
        repeat (26) @(negedge clk);
        check("mid_vld_pc", {28'b0, gpio2[31:24]}, 36'd24);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("abort_q", {20'b0, q}, 36'd0);
        check("abort_gpio2", gpio2, 36'd0);
        switches = 5'b10000;
        read_addr(24'd4, 16'd0);
        read_addr(24'd15, 16'd0);
        switches = 5'b00001;
        repeat (53) @(negedge clk);
        verify_final();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
